// File: rtl/camera_config_sequencer.sv
// Walks the OV7670 configuration ROM and hands each register write to the SCCB writer.
// Delay markers pause the run; an end marker or table exhaustion finishes it cleanly.
module camera_config_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int DELAY_CYCLES   = 2000,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_200_khz,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic [15:0]       i2c_data_o,
    output logic              i2c_valid_o,
    input  logic              i2c_ready_i,
    input  logic              i2c_error_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [7:0]        write_count_o
);
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_ISSUE     = 4'd3,
        ST_WAIT_DONE = 4'd4,
        ST_WAIT      = 4'd5,
        ST_ADVANCE   = 4'd6,
        ST_GAP       = 4'd7,
        ST_DONE      = 4'd8,
        ST_ERROR     = 4'd9
    } state_t;

    localparam logic [15:0]       END_WORD   = 16'hFFFF;
    localparam logic [15:0]       DELAY_WORD = 16'hFFF0;
    localparam logic [15:0]       DELAY_LOAD = 16'(DELAY_CYCLES - 1);
    localparam logic [15:0]       GAP_LOAD   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0]       TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [15:0] to_cnt_r;

    logic is_end_s;
    logic is_delay_s;
    logic to_hit_s;
    logic cnt_zero_s;

    // Entry decode and counter terminal conditions.
    always_comb begin
        is_end_s   = 1'b0;
        is_delay_s = 1'b0;
        is_end_s   = (rom_data_i == END_WORD);
        is_delay_s = (rom_data_i == DELAY_WORD);
        // The timeout fires on the edge that would take the count to TIMEOUT_CYCLES.
        to_hit_s   = (to_cnt_r == TO_LAST);
        cnt_zero_s = (cnt_r == 16'd0);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_200_khz or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= ST_IDLE;
            rom_addr_o    <= '0;
            i2c_data_o    <= 16'd0;
            i2c_valid_o   <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            write_count_o <= 8'd0;
            cnt_r         <= 16'd0;
            to_cnt_r      <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        rom_addr_o    <= '0;
                        write_count_o <= 8'd0;
                        done_o        <= 1'b0;
                        error_o       <= 1'b0;
                        busy_o        <= 1'b1;
                        state_r       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_end_s) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (is_delay_s) begin
                        cnt_r   <= DELAY_LOAD;
                        state_r <= ST_WAIT;
                    end else begin
                        i2c_data_o  <= rom_data_i;
                        i2c_valid_o <= 1'b1;
                        to_cnt_r    <= 16'd0;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt_r <= to_cnt_r + 16'd1;
                    if (to_hit_s) begin
                        i2c_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        error_o     <= 1'b1;
                        state_r     <= ST_ERROR;
                    end else if (!i2c_ready_i) begin
                        i2c_valid_o <= 1'b0;
                        state_r     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    to_cnt_r <= to_cnt_r + 16'd1;
                    // Timeout and a NACK both beat completion; i2c_data_o stays put for the writer.
                    if (to_hit_s || (i2c_ready_i && i2c_error_i)) begin
                        busy_o  <= 1'b0;
                        error_o <= 1'b1;
                        state_r <= ST_ERROR;
                    end else if (i2c_ready_i) begin
                        if (write_count_o != 8'hFF) begin
                            write_count_o <= write_count_o + 8'd1;
                        end
                        state_r <= ST_ADVANCE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_ADVANCE;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_ADVANCE: begin
                    // A table with no end marker finishes on its last slot instead of wrapping.
                    if (rom_addr_o == ADDR_LAST) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        rom_addr_o <= rom_addr_o + ADDR_ONE;
                        cnt_r      <= GAP_LOAD;
                        state_r    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_FETCH;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    i2c_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                    error_o     <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_camera_config_sequencer.sv
// Bench for camera_config_sequencer: table-driven runs against a writer model, a write
// scoreboard, and hand sequences for reset, restart and short-table corners.
module tb_camera_config_sequencer;
    localparam int WR_LEN = 64;

    typedef struct packed {
        logic [3:0][15:0] rom;
        int               nack;
        bit               hang;
        int               n_exp;
        logic [1:0][15:0] exp_w;
        int               min_gap;
        bit               exp_done;
        bit               exp_err;
        logic [7:0]       exp_cnt;
    } vec_t;

    logic clk_200_khz = 1'b0;
    logic reset_i     = 1'b1;
    int   cyc         = 0;
    int   n_cmp       = 0;
    int   n_bad       = 0;

    // DUT 1: default parameters
    logic        start_i = 1'b0;
    logic [7:0]  rom_addr1;
    logic [15:0] rom_data1;
    logic [15:0] data1;
    logic        valid1, ready1, error_in1, busy1, done1, err1;
    logic [7:0]  count1;
    logic [15:0] rom1 [256];

    // DUT 2: four-entry table
    logic        start2 = 1'b0;
    logic [1:0]  rom_addr2;
    logic [15:0] rom_data2;
    logic [15:0] data2;
    logic        valid2, ready2, busy2, done2, err2;
    logic [7:0]  count2;
    logic [15:0] rom2 [4];

    camera_config_sequencer dut (
        .clk_200_khz(clk_200_khz), .reset_i(reset_i), .start_i(start_i),
        .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
        .i2c_data_o(data1), .i2c_valid_o(valid1), .i2c_ready_i(ready1), .i2c_error_i(error_in1),
        .busy_o(busy1), .done_o(done1), .error_o(err1), .write_count_o(count1)
    );

    camera_config_sequencer #(.ADDR_W(2)) dut2 (
        .clk_200_khz(clk_200_khz), .reset_i(reset_i), .start_i(start2),
        .rom_addr_o(rom_addr2), .rom_data_i(rom_data2),
        .i2c_data_o(data2), .i2c_valid_o(valid2), .i2c_ready_i(ready2), .i2c_error_i(1'b0),
        .busy_o(busy2), .done_o(done2), .error_o(err2), .write_count_o(count2)
    );

    initial forever #5 clk_200_khz = ~clk_200_khz;
    always @(posedge clk_200_khz) cyc <= cyc + 1;
    always @(posedge clk_200_khz) rom_data1 <= rom1[rom_addr1];
    always @(posedge clk_200_khz) rom_data2 <= rom2[rom_addr2];

    // Writer models: accept on valid while idle, stay busy WR_LEN cycles.
    int          nack_idx1 = -1;
    logic        hang1     = 1'b0;
    logic        wr_busy1, wr_err1, wr_busy2;
    int          wr_cnt1, wr_txn1, wr_cnt2;
    logic [15:0] wr_data1;

    always @(posedge clk_200_khz or posedge reset_i) begin
        if (reset_i) begin
            wr_busy1 <= 1'b0; wr_err1 <= 1'b0; wr_cnt1 <= 0; wr_txn1 <= 0; wr_data1 <= 16'd0;
        end else if (!wr_busy1 && valid1) begin
            wr_busy1 <= 1'b1; wr_cnt1 <= WR_LEN; wr_data1 <= data1; wr_txn1 <= wr_txn1 + 1;
            if (wr_txn1 == nack_idx1) wr_err1 <= 1'b1;
        end else if (wr_busy1 && !hang1) begin
            if (wr_cnt1 == 1) wr_busy1 <= 1'b0;
            wr_cnt1 <= wr_cnt1 - 1;
        end
    end
    assign ready1    = !wr_busy1 && !valid1;
    assign error_in1 = wr_err1;

    always @(posedge clk_200_khz or posedge reset_i) begin
        if (reset_i) begin
            wr_busy2 <= 1'b0; wr_cnt2 <= 0;
        end else if (!wr_busy2 && valid2) begin
            wr_busy2 <= 1'b1; wr_cnt2 <= WR_LEN;
        end else if (wr_busy2) begin
            if (wr_cnt2 == 1) wr_busy2 <= 1'b0;
            wr_cnt2 <= wr_cnt2 - 1;
        end
    end
    assign ready2 = !wr_busy2 && !valid2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards and monitors, sampled on the falling edge.
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    int   vcnt1 = 0, vcnt2 = 0, rise_cyc = 0, last_gap = 0, last_valid_cyc = 0;
    logic prev_busy1 = 1'b0;

    always @(negedge clk_200_khz) begin
        if (prev_busy1 && !wr_busy1) rise_cyc = cyc;
        prev_busy1 = wr_busy1;
        if (valid1 && !wr_busy1) begin
            vcnt1++;
            last_gap       = cyc - rise_cyc;
            last_valid_cyc = cyc;
            check("write_queued", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) check("write_data", 64'(data1), 64'(q1.pop_front()));
        end
        if (wr_busy1) check("data_hold", 64'(data1), 64'(wr_data1));
    end

    always @(negedge clk_200_khz) begin
        if (valid2 && !wr_busy2) begin
            vcnt2++;
            check("write_queued2", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) check("write_data2", 64'(data2), 64'(q2.pop_front()));
        end
    end

    task automatic apply_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_200_khz);
        reset_i = 1'b0;
        @(negedge clk_200_khz);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_200_khz);
        start_i = 1'b0;
    endtask

    task automatic wait_end(output int end_cyc);
        int n = 0;
        while (!(done1 || err1) && n < 8000) begin
            @(negedge clk_200_khz);
            n++;
        end
        check("run_ends", 64'(done1 || err1), 64'd1);
        end_cyc = cyc;
    endtask

    task automatic load_rom1(input logic [3:0][15:0] r);
        for (int k = 0; k < 256; k++) rom1[k] = 16'hFFFF;
        for (int k = 0; k < 4; k++) rom1[k] = r[k];
    endtask

    function automatic vec_t mk(input logic [15:0] r0, r1, r2, r3, input int nack, input bit hang,
                                input int n, input logic [15:0] e0, e1, input int gap,
                                input bit d, input bit e, input logic [7:0] c);
        vec_t v;
        v.rom = {r3, r2, r1, r0};
        v.nack = nack; v.hang = hang; v.n_exp = n; v.exp_w = {e1, e0};
        v.min_gap = gap; v.exp_done = d; v.exp_err = e; v.exp_cnt = c;
        return v;
    endfunction

    vec_t vecs [5];

    initial begin
        int end_cyc;
        int base;
        vecs[0] = mk(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF, -1, 1'b0, 2, 16'h1280, 16'h1101, 2005, 1'b1, 1'b0, 8'd2);
        vecs[1] = mk(16'h3A04, 16'h40D0, 16'hFFFF, 16'hFFFF,  1, 1'b0, 2, 16'h3A04, 16'h40D0, 0, 1'b0, 1'b1, 8'd1);
        vecs[2] = mk(16'h5555, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 1'b1, 1, 16'h5555, 16'h0000, 0, 1'b0, 1'b1, 8'd0);
        vecs[3] = mk(16'hFFFF, 16'h1234, 16'hFFFF, 16'hFFFF, -1, 1'b0, 0, 16'h0000, 16'h0000, 0, 1'b1, 1'b0, 8'd0);
        vecs[4] = mk(16'hAAAA, 16'hFFF0, 16'hFFFF, 16'hFFFF, -1, 1'b0, 1, 16'hAAAA, 16'h0000, 0, 1'b1, 1'b0, 8'd1);
        for (int k = 0; k < 256; k++) rom1[k] = 16'hFFFF;
        for (int k = 0; k < 4; k++) rom2[k] = 16'hFFFF;

        apply_reset();
        check("reset_state", {busy1, valid1, done1, err1, rom_addr1, count1, data1}, 64'd0);
        check("reset_state2", {busy2, valid2, done2, err2, rom_addr2, count2, data2}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            nack_idx1 = vecs[i].nack;
            hang1     = vecs[i].hang;
            apply_reset();
            load_rom1(vecs[i].rom);
            q1.delete();
            for (int k = 0; k < vecs[i].n_exp; k++) q1.push_back(vecs[i].exp_w[k]);
            base = vcnt1;
            pulse_start();
            wait_end(end_cyc);
            check("done", 64'(done1), 64'(vecs[i].exp_done));
            check("error", 64'(err1), 64'(vecs[i].exp_err));
            check("write_count", 64'(count1), 64'(vecs[i].exp_cnt));
            check("idle_outputs", {busy1, valid1}, 64'd0);
            if (vecs[i].hang) check("timeout_latency", 64'(end_cyc - last_valid_cyc), 64'd255);
            if (vecs[i].min_gap > 0) check("delay_gap_ok", 64'(last_gap >= vecs[i].min_gap), 64'd1);
            repeat (80) @(negedge clk_200_khz);
            check("valid_count", 64'(vcnt1 - base), 64'(vecs[i].n_exp));
            check("queue_empty", 64'(q1.size()), 64'd0);
        end
        nack_idx1 = -1;
        hang1     = 1'b0;

        // Reset while the writer is mid-transaction, then a clean rerun.
        apply_reset();
        load_rom1({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1280});
        q1.delete();
        q1.push_back(16'h1280);
        pulse_start();
        for (int n = 0; n < 20 && !wr_busy1; n++) @(negedge clk_200_khz);
        check("writer_started", 64'(wr_busy1), 64'd1);
        repeat (10) @(negedge clk_200_khz);
        #2 reset_i = 1'b1;
        #1 check("async_reset", {busy1, valid1, done1, err1, rom_addr1, count1, data1}, 64'd0);
        @(negedge clk_200_khz);
        reset_i = 1'b0;
        @(negedge clk_200_khz);
        q1.push_back(16'h1280);
        base = vcnt1;
        pulse_start();
        wait_end(end_cyc);
        check("rerun_done", {done1, err1, count1}, {1'b1, 1'b0, 8'd1});
        check("rerun_valid_count", 64'(vcnt1 - base), 64'd1);

        // start_i during GAP is ignored.
        apply_reset();
        load_rom1({16'hFFFF, 16'hFFFF, 16'h1101, 16'h1280});
        q1.push_back(16'h1280);
        q1.push_back(16'h1101);
        base = vcnt1;
        pulse_start();
        for (int n = 0; n < 200 && rom_addr1 != 8'd1; n++) @(negedge clk_200_khz);
        start_i = 1'b1;
        repeat (2) @(negedge clk_200_khz);
        start_i = 1'b0;
        check("gap_start_ignored", {busy1, rom_addr1, count1}, {1'b1, 8'd1, 8'd1});
        wait_end(end_cyc);
        check("gap_run_done", {done1, err1, count1}, {1'b1, 1'b0, 8'd2});
        check("gap_valid_count", 64'(vcnt1 - base), 64'd2);

        // start_i in DONE restarts from entry 0.
        q1.push_back(16'h1280);
        q1.push_back(16'h1101);
        base = vcnt1;
        pulse_start();
        check("restart_clears", {done1, busy1, rom_addr1, count1}, {1'b0, 1'b1, 8'd0, 8'd0});
        wait_end(end_cyc);
        check("restart_done", {done1, err1, count1}, {1'b1, 1'b0, 8'd2});
        check("restart_valid_count", 64'(vcnt1 - base), 64'd2);

        // Four-entry table with no end marker.
        rom2[0] = 16'h0102; rom2[1] = 16'h0304; rom2[2] = 16'h0506; rom2[3] = 16'h0708;
        for (int k = 0; k < 4; k++) q2.push_back(rom2[k]);
        start2 = 1'b1;
        @(negedge clk_200_khz);
        start2 = 1'b0;
        for (int n = 0; n < 2000 && !done2; n++) @(negedge clk_200_khz);
        check("short_done", {done2, err2, count2, rom_addr2}, {1'b1, 1'b0, 8'd4, 2'd3});
        repeat (20) @(negedge clk_200_khz);
        check("short_no_wrap", {done2, busy2, rom_addr2}, {1'b1, 1'b0, 2'd3});
        check("short_valid_count", 64'(vcnt2), 64'd4);
        check("short_queue_empty", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
